// File: rtl/hash160_digest_tx.sv
// Hash160 result transmitter: captures the digest on a rising edge of the core's valid level
// and streams it MSB byte first (raw bytes or lowercase ASCII hex) over valid/ready.
module hash160_digest_tx #(
  parameter int unsigned DIGEST_BYTES = 20,
  parameter bit          HEX_ASCII    = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  input  logic [DIGEST_BYTES*8-1:0] i_answer,
  output logic [7:0]                o_data,
  output logic                      o_data_valid,
  input  logic                      i_data_ready,
  output logic                      o_last,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam int unsigned W         = DIGEST_BYTES * 8;
  localparam int unsigned NBEATS    = HEX_ASCII ? 2 * DIGEST_BYTES : DIGEST_BYTES;
  localparam int unsigned SHIFT     = HEX_ASCII ? 4 : 8;
  localparam logic [5:0]  LAST_BEAT = 6'(NBEATS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state_q, state_d;
  logic [5:0]   cnt_q, cnt_d;
  logic [W-1:0] shreg_q, shreg_d;
  logic         valid_dly_q;

  logic       start;
  logic       xfer;
  logic [3:0] nib;
  logic [7:0] hex_char;
  logic [7:0] beat;

  assign start = i_valid & ~valid_dly_q;
  assign xfer  = (state_q == ST_SEND) & i_data_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          shreg_d = i_answer;
          cnt_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          shreg_d = shreg_q << SHIFT;
          // The counter parks on the final beat instead of wrapping.
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      valid_dly_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      valid_dly_q <= i_valid;
    end
  end

  assign nib      = shreg_q[W-1 -: 4];
  assign hex_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
  assign beat     = HEX_ASCII ? hex_char : shreg_q[W-1 -: 8];

  // Output is forced to zero outside SEND so hex mode does not show '0' (0x30) at reset.
  assign o_data       = (state_q == ST_SEND) ? beat : '0;
  assign o_data_valid = (state_q == ST_SEND);
  assign o_last       = (cnt_q == LAST_BEAT) & o_data_valid;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_hash160_digest_tx.sv
// Bench for hash160_digest_tx: a raw and a hex instance share stimulus; beats are collected
// by a monitor and compared with digest-derived expectations.
module tb_hash160_digest_tx;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_valid;
  logic [159:0] i_answer;
  logic         ready;

  logic [7:0] data [2];
  logic       dv   [2];
  logic       last [2];
  logic       busy [2];
  logic       done [2];

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt [2];
  int mon_idx;

  logic [7:0] got_raw [$];
  logic [7:0] got_hex [$];
  logic [7:0] exp_raw [$];
  logic [7:0] exp_hex [$];

  bit         prev_stall [2];
  logic [7:0] prev_data  [2];
  logic       prev_last  [2];

  always #5 clk = ~clk;

  hash160_digest_tx #(.DIGEST_BYTES(20), .HEX_ASCII(1'b0)) u_raw (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_answer(i_answer),
    .o_data(data[0]), .o_data_valid(dv[0]), .i_data_ready(ready),
    .o_last(last[0]), .o_busy(busy[0]), .o_done(done[0])
  );

  hash160_digest_tx #(.DIGEST_BYTES(20), .HEX_ASCII(1'b1)) u_hex (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_answer(i_answer),
    .o_data(data[1]), .o_data_valid(dv[1]), .i_data_ready(ready),
    .o_last(last[1]), .o_busy(busy[1]), .o_done(done[1])
  );

  // Inputs change just after posedge, so the negedge view is what the next posedge samples.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        prev_stall[k] = 1'b0;
      end else begin
        if (prev_stall[k]) begin
          n_checks++;
          if (dv[k] !== 1'b1 || data[k] !== prev_data[k] || last[k] !== prev_last[k]) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                     k, dv[k], data[k], last[k], prev_data[k], prev_last[k]);
          end
        end
        if (dv[k] && ready) begin
          mon_idx = (k == 0) ? got_raw.size() : got_hex.size();
          n_checks++;
          if (last[k] !== (mon_idx == ((k == 0) ? 19 : 39))) begin
            n_fail++;
            $display("FAIL o_last[%0d] beat %0d: got %b exp %b", k, mon_idx, last[k],
                     (mon_idx == ((k == 0) ? 19 : 39)));
          end
          if (k == 0) got_raw.push_back(data[k]);
          else        got_hex.push_back(data[k]);
        end
        if (done[k]) done_cnt[k]++;
        prev_stall[k] = dv[k] && !ready;
        prev_data[k]  = data[k];
        prev_last[k]  = last[k];
      end
    end
  end

  function automatic logic [7:0] hexch(input logic [3:0] n);
    return (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd97 + 8'(n) - 8'd10);
  endfunction

  task automatic build_exp(input logic [159:0] d);
    logic [7:0] b;
    for (int i = 0; i < 20; i++) begin
      b = 8'(d >> (8 * (19 - i)));
      exp_raw.push_back(b);
      exp_hex.push_back(hexch(b[7:4]));
      exp_hex.push_back(hexch(b[3:0]));
    end
  endtask

  task automatic clear_all();
    got_raw.delete(); got_hex.delete(); exp_raw.delete(); exp_hex.delete();
    done_cnt[0] = 0; done_cnt[1] = 0;
  endtask

  task automatic drive_ready(input int mode, input int cyc);
    case (mode)
      0:       ready = 1'b1;
      1:       ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      default: ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic wait_idle(input int mode, output bit timed_out);
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      drive_ready(mode, cyc);
      cyc++;
    end while ((cyc < 3 || busy[0] || busy[1]) && cyc < 600);
    timed_out = (cyc >= 600);
  endtask

  task automatic send(input logic [159:0] d, input int mode, output bit timed_out);
    clear_all();
    build_exp(d);
    @(posedge clk); #1 i_valid = 1'b0; drive_ready(mode, 0);
    @(posedge clk); #1 i_valid = 1'b1; i_answer = d;
    wait_idle(mode, timed_out);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_answer = '0; ready = 1'b1;
    #3;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({data[k], dv[k], last[k], busy[k], done[k]} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs[%0d]: got %h exp 000", k, {data[k], dv[k], last[k], busy[k], done[k]});
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_raw_ready_high();
    logic [159:0] d = 160'h00112233445566778899aabbccddeeff01234567;
    int cyc;
    bit to;
    clear_all();
    build_exp(d);
    ready = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    @(posedge clk); #1 i_valid = 1'b1; i_answer = d;
    @(posedge clk); #1;
    n_checks++;
    if (dv[0] !== 1'b1 || data[0] !== 8'h00 || dv[1] !== 1'b1 || data[1] !== 8'h30) begin
      n_fail++;
      $display("FAIL first_beat_latency: got v=%b/%b d=%h/%h exp v=1/1 d=00/30", dv[0], dv[1], data[0], data[1]);
    end
    cyc = 0;
    while (!done[0] && cyc < 100) begin @(posedge clk); #1; cyc++; end
    n_checks++;
    if (cyc !== 20) begin
      n_fail++;
      $display("FAIL done_latency: got %0d exp 20 cycles after first beat", cyc);
    end
    @(posedge clk); #1;
    n_checks++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse_width: got done=%b busy=%b exp 0 0", done[0], busy[0]);
    end
    wait_idle(0, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL raw_timeout: got busy exp idle"); end
    n_checks++;
    if (got_raw != exp_raw || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL raw_stream: got %0d/%0d beats done %0d/%0d exp 20/40 beats done 1/1 with matching data",
               got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_backpressure();
    bit to;
    send(160'h00112233445566778899aabbccddeeff01234567, 1, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL backpressure_timeout: got busy exp idle"); end
    for (int i = 0; i < 20; i++) begin
      n_checks++;
      if (i >= got_raw.size() || got_raw[i] !== exp_raw[i]) begin
        n_fail++;
        $display("FAIL backpressure_beat[%0d]: got %h exp %h", i, (i < got_raw.size()) ? got_raw[i] : 8'hxx, exp_raw[i]);
      end
    end
    n_checks++;
    if (got_raw.size() != 20 || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL backpressure_totals: got %0d/%0d beats done %0d/%0d exp 20/40 done 1/1",
               got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_retrigger();
    bit to;
    clear_all();
    ready = 1'b1;
    repeat (60) @(posedge clk);
    #1;
    n_checks++;
    if (got_raw.size() != 0 || got_hex.size() != 0 || busy[0] || busy[1] || done_cnt[0] != 0) begin
      n_fail++;
      $display("FAIL held_level_no_resend: got %0d/%0d beats exp 0/0", got_raw.size(), got_hex.size());
    end
    send({160{1'b1}}, 0, to);
    n_checks++;
    if (to || got_raw != exp_raw || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL retrigger_all_ff: got %0d/%0d beats done %0d/%0d exp 20/40 done 1/1",
               got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_edge_while_busy();
    logic [159:0] d1 = 160'h0123456789abcdef0123456789abcdef01234567;
    int cyc;
    bit to;
    clear_all();
    build_exp(d1);
    ready = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    @(posedge clk); #1 i_valid = 1'b1; i_answer = d1;
    cyc = 0;
    while (got_raw.size() < 5 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    i_valid = 1'b0; i_answer = ~d1;
    @(posedge clk); #1 i_valid = 1'b1;
    wait_idle(0, to);
    repeat (50) @(posedge clk);
    #1;
    n_checks++;
    if (to || got_raw != exp_raw || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL edge_while_busy: got %0d/%0d beats done %0d/%0d exp 20/40 done 1/1",
               got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_hex();
    bit to;
    send(160'habcdef0123456789abcdef0123456789abcdef01, 2, to);
    n_checks++;
    if (to) begin n_fail++; $display("FAIL hex_timeout: got busy exp idle"); end
    for (int i = 0; i < 40; i++) begin
      n_checks++;
      if (i >= got_hex.size() || got_hex[i] !== exp_hex[i]) begin
        n_fail++;
        $display("FAIL hex_beat[%0d]: got %h exp %h", i, (i < got_hex.size()) ? got_hex[i] : 8'hxx, exp_hex[i]);
      end
    end
    n_checks++;
    if (got_hex.size() != 40 || got_raw != exp_raw || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL hex_totals: got %0d beats done %0d exp 40 done 1", got_hex.size(), done_cnt[1]);
    end
  endtask

  task automatic test_reset_mid();
    logic [159:0] d = {$urandom, $urandom, $urandom, $urandom, $urandom};
    int cyc;
    bit to;
    clear_all();
    ready = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    @(posedge clk); #1 i_valid = 1'b1; i_answer = d;
    cyc = 0;
    while (got_raw.size() < 7 && cyc < 100) begin @(posedge clk); #1; cyc++; end
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({data[k], dv[k], last[k], busy[k], done[k]} !== 12'h000) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: got %h exp 000", k, {data[k], dv[k], last[k], busy[k], done[k]});
      end
    end
    clear_all();
    build_exp(d);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_idle(0, to);
    n_checks++;
    if (to || got_raw != exp_raw || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
      n_fail++;
      $display("FAIL resend_after_reset: got %0d/%0d beats done %0d/%0d exp 20/40 done 1/1",
               got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
    end
  endtask

  task automatic test_random();
    bit to;
    for (int t = 0; t < 4; t++) begin
      send({$urandom, $urandom, $urandom, $urandom, $urandom}, 2, to);
      n_checks++;
      if (to || got_raw != exp_raw || got_hex != exp_hex || done_cnt[0] != 1 || done_cnt[1] != 1) begin
        n_fail++;
        $display("FAIL random_digest[%0d]: got %0d/%0d beats done %0d/%0d exp 20/40 done 1/1",
                 t, got_raw.size(), got_hex.size(), done_cnt[0], done_cnt[1]);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish exp finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_raw_ready_high();
    test_backpressure();
    test_retrigger();
    test_edge_while_busy();
    test_hex();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
